// File: rtl/led_bank_sequencer.sv
// led_bank_sequencer: DIP-switch driven pattern sequencer for three LED banks
// plus an 8-bit status bank. All switch inputs are double-synchronized; a
// tick-paced IDLE/LOAD/RUN/PAUSE FSM steps one of four patterns.
// Optional feature: define LED_SEQ_PWM_EN to build a 4-bit PWM brightness
// gate on lb0..lb2 (dsw1[7:4]); without it the banks are ungated.
module led_bank_sequencer #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dsw0,
    input  logic [7:0] dsw1,
    input  logic [7:0] dsw2,
    output logic [7:0] lb0,
    output logic [7:0] lb1,
    output logic [7:0] lb2,
    output logic [7:0] led
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam logic [1:0] M_COUNT = 2'd0;
    localparam logic [1:0] M_CHASE = 2'd1;
    localparam logic [1:0] M_BANK  = 2'd2;
    localparam logic [1:0] M_PING  = 2'd3;

    state_t          state_q, state_d;
    logic [23:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      pat_q, pat_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      mode_q, mode_d;
    logic            bdir_q, bdir_d;    // ping-pong direction, 1 = moving right
    logic            hb_q, hb_d;
    logic [2:0][7:0] lb_q, lb_d;
    logic [7:0]      led_q, led_d;

    // Synchronized switch views
    logic [7:0] sw0, sw1, sw2;
    logic [1:0] mode_s;
    logic       run_s, dir_s, mode_chg, tick, lit;
    logic [2:0] en;
    logic [1:0] idx_up, idx_dn, idx_first, idx_second, idx_nxt;
    logic       unused_sw;

    assign sw0      = sync2_q[7:0];
    assign sw1      = sync2_q[15:8];
    assign sw2      = sync2_q[23:16];
    assign mode_s   = sw1[1:0];
    assign run_s    = sw1[2];
    assign dir_s    = sw1[3];
    assign en       = sw2[2:0];
    assign mode_chg = (mode_s != mode_q);
    assign tick     = (state_q == S_RUN) && (presc_q == PRESC_MAX);

`ifdef LED_SEQ_PWM_EN
    logic [3:0] pwm_q, pwm_d;
    logic [3:0] bright;
    assign bright    = sw1[7:4];
    assign lit       = (bright == 4'hF) || (pwm_q < bright);
    assign unused_sw = ^sw2[7:3];

    // Free-running PWM phase counter
    always_comb pwm_d = pwm_q + 4'd1;

    // PWM counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_d;
    end
`else
    assign lit       = 1'b1;
    assign unused_sw = ^{sw2[7:3], sw1[7:4]};
`endif

    // Two-stage switch synchronizer inputs
    always_comb begin
        sync1_d = {dsw2, dsw1, dsw0};
        sync2_d = sync1_q;
    end

    // Next enabled bank in the selected direction; holds if none other is enabled
    always_comb begin
        idx_up     = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        idx_dn     = (idx_q == 2'd0) ? 2'd2 : idx_q - 2'd1;
        idx_first  = dir_s ? idx_dn : idx_up;
        idx_second = dir_s ? idx_up : idx_dn;
        if (en[idx_first])       idx_nxt = idx_first;
        else if (en[idx_second]) idx_nxt = idx_second;
        else                     idx_nxt = idx_q;
    end

    // FSM next state, prescaler and pattern stepping
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        bdir_d  = bdir_q;
        hb_d    = hb_q;
        unique case (state_q)
            S_IDLE: begin
                if (run_s) state_d = S_LOAD;
            end
            S_LOAD: begin
                mode_d  = mode_s;
                idx_d   = 2'd0;
                bdir_d  = 1'b0;
                presc_d = '0;
                unique case (mode_s)
                    M_COUNT: pat_d = 8'h00;
                    M_CHASE: pat_d = dir_s ? 8'h80 : 8'h01;
                    M_BANK:  pat_d = 8'h00;   // bank mode shows dsw0 live
                    M_PING:  pat_d = 8'h01;
                endcase
                state_d = S_RUN;
            end
            S_RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    hb_d = ~hb_q;
                    unique case (mode_q)
                        M_COUNT: pat_d = dir_s ? pat_q - 8'd1 : pat_q + 8'd1;
                        M_CHASE: pat_d = dir_s ? {pat_q[0], pat_q[7:1]}
                                               : {pat_q[6:0], pat_q[7]};
                        M_BANK:  idx_d = idx_nxt;
                        M_PING: begin
                            if (!bdir_q) begin
                                if (pat_q == 8'h80) begin
                                    bdir_d = 1'b1;
                                    pat_d  = 8'h40;
                                end else begin
                                    pat_d = pat_q << 1;
                                end
                            end else begin
                                if (pat_q == 8'h01) begin
                                    bdir_d = 1'b0;
                                    pat_d  = 8'h02;
                                end else begin
                                    pat_d = pat_q >> 1;
                                end
                            end
                        end
                    endcase
                end
                if (mode_chg)    state_d = S_LOAD;
                else if (!run_s) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (mode_chg)   state_d = S_LOAD;
                else if (run_s) state_d = S_RUN;
            end
        endcase
    end

    // Registered bank and status outputs, one cycle behind the pattern state
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            lb_d[n] = 8'h00;
            if (state_q != S_IDLE) begin
                if (mode_q == M_BANK) begin
                    if (idx_q == 2'(n) && en[n]) lb_d[n] = sw0;
                end else if (en[n]) begin
                    lb_d[n] = pat_q & sw0;
                end
            end
            if (!lit) lb_d[n] = 8'h00;
        end
        led_d = {hb_q, dir_s, idx_q, mode_q, state_q};
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
            mode_q  <= '0;
            bdir_q  <= 1'b0;
            hb_q    <= 1'b0;
            lb_q    <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            bdir_q  <= bdir_d;
            hb_q    <= hb_d;
            lb_q    <= lb_d;
            led_q   <= led_d;
        end
    end

    assign lb0 = lb_q[0];
    assign lb1 = lb_q[1];
    assign lb2 = lb_q[2];
    assign led = led_q;

endmodule
